// File: rtl/qrd_givens_sched_if.sv
// Handshake and buffer-control bundle between the QRD Givens scheduler and
// its surroundings (sample source, matrix buffer, CORDIC PEs, R consumer).
// Optional macro QRD_CYCLE_CNT_EN adds the cycle_cnt signal.
interface qrd_givens_sched_if #(
  parameter int ADDR_W = 4
);
  logic              valid_i;
  logic              in_ready;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [ADDR_W-1:0] rd_addr;
  logic              vec_en;
  logic              rot_en;
  logic [3:0]        iter;
  logic              wb;
  logic [1:0]        row_top;
  logic [1:0]        row_bot;
  logic [1:0]        col;
  logic              out_valid;
  logic              out_ready;
  logic              busy;
  logic              done;
`ifdef QRD_CYCLE_CNT_EN
  logic [15:0]       cycle_cnt;
`endif

  // Scheduler side
  modport master (
    input  valid_i, out_ready,
`ifdef QRD_CYCLE_CNT_EN
    output cycle_cnt,
`endif
    output in_ready, wr_en, wr_addr, rd_addr, vec_en, rot_en, iter, wb,
           row_top, row_bot, col, out_valid, busy, done
  );

  // Environment side (sample source, buffer, PEs, R consumer)
  modport slave (
    output valid_i, out_ready,
`ifdef QRD_CYCLE_CNT_EN
    input  cycle_cnt,
`endif
    input  in_ready, wr_en, wr_addr, rd_addr, vec_en, rot_en, iter, wb,
           row_top, row_bot, col, out_valid, busy, done
  );
endinterface

// File: rtl/qrd_givens_sched.sv
// Scheduler for the 4x4 complex QR-decomposition core.
// Loads a 16-sample matrix, walks the CORDIC PEs through the Givens schedule
// (PE1 vectoring, PE2 rotation), then streams R out of the matrix buffer.
// Optional macro QRD_CYCLE_CNT_EN: adds cycle_cnt, the length of the last
// VEC/ROT phase in clock cycles.
module qrd_givens_sched #(
  parameter int ROTATION_NUM = 14,
  parameter int ADDR_W       = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  qrd_givens_sched_if.master  io_sched
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_VEC,
    S_ROT,
    S_OUT
  } state_t;

  localparam logic [3:0]        ITER_LAST = 4'(ROTATION_NUM - 1);
  localparam logic [3:0]        ITER_WB   = 4'(ROTATION_NUM);
  localparam logic [ADDR_W-1:0] ADDR_LAST = '1;
  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);

  state_t            r_state;
  logic [ADDR_W-1:0] r_load_cnt;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [ADDR_W-1:0] r_rd_addr;
  logic              r_wr_en;
  logic              r_vec_en;
  logic              r_rot_en;
  logic              r_wb;
  logic [3:0]        r_iter;
  logic [1:0]        r_row_top;
  logic [1:0]        r_row_bot;
  logic [1:0]        r_col;
  logic [1:0]        r_j;
  logic              r_out_valid;
  logic              r_busy;
  logic              r_done;
`ifdef QRD_CYCLE_CNT_EN
  logic [15:0]       r_cycle_cnt;
`endif

  logic w_in_ready;
  logic w_accept;

  // in_ready is the only output decoded straight from state
  assign w_in_ready = (r_state == S_IDLE) || (r_state == S_LOAD);
  assign w_accept   = io_sched.valid_i & w_in_ready;

  assign io_sched.in_ready  = w_in_ready;
  assign io_sched.wr_en     = r_wr_en;
  assign io_sched.wr_addr   = r_wr_addr;
  assign io_sched.rd_addr   = r_rd_addr;
  assign io_sched.vec_en    = r_vec_en;
  assign io_sched.rot_en    = r_rot_en;
  assign io_sched.iter      = r_iter;
  assign io_sched.wb        = r_wb;
  assign io_sched.row_top   = r_row_top;
  assign io_sched.row_bot   = r_row_bot;
  assign io_sched.col       = r_col;
  assign io_sched.out_valid = r_out_valid;
  assign io_sched.busy      = r_busy;
  assign io_sched.done      = r_done;
`ifdef QRD_CYCLE_CNT_EN
  assign io_sched.cycle_cnt = r_cycle_cnt;
`endif

  // Main FSM: load addressing, Givens step sequencing, R readout; all outputs registered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_load_cnt  <= '0;
      r_wr_addr   <= '0;
      r_rd_addr   <= '0;
      r_wr_en     <= 1'b0;
      r_vec_en    <= 1'b0;
      r_rot_en    <= 1'b0;
      r_wb        <= 1'b0;
      r_iter      <= '0;
      r_row_top   <= '0;
      r_row_bot   <= '0;
      r_col       <= '0;
      r_j         <= '0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
`ifdef QRD_CYCLE_CNT_EN
      r_cycle_cnt <= '0;
`endif
    end else begin
      // Write strobe and done are single-cycle pulses unless re-asserted below
      r_wr_en <= 1'b0;
      r_done  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_wr_en    <= 1'b1;
            r_wr_addr  <= '0;
            r_load_cnt <= ADDR_ONE;
            r_busy     <= 1'b1;
            r_state    <= S_LOAD;
          end
        end

        S_LOAD: begin
          if (w_accept) begin
            r_wr_en    <= 1'b1;
            r_wr_addr  <= r_load_cnt;
            r_load_cnt <= r_load_cnt + ADDR_ONE;
            if (r_load_cnt == ADDR_LAST) begin
              // Matrix complete: first step is vectoring (i=3, j=0) on column 0
              r_state   <= S_VEC;
              r_j       <= 2'd0;
              r_row_top <= 2'd2;
              r_row_bot <= 2'd3;
              r_col     <= 2'd0;
              r_vec_en  <= 1'b1;
              r_iter    <= '0;
`ifdef QRD_CYCLE_CNT_EN
              r_cycle_cnt <= '0;
`endif
            end
          end
        end

        S_VEC, S_ROT: begin
`ifdef QRD_CYCLE_CNT_EN
          r_cycle_cnt <= r_cycle_cnt + 16'd1;
`endif
          if (r_wb) begin
            // Writeback cycle ends the op; pick the next op of the schedule
            r_wb   <= 1'b0;
            r_iter <= '0;
            if (r_state == S_VEC) begin
              r_state  <= S_ROT;
              r_col    <= r_j + 2'd1;
              r_rot_en <= 1'b1;
            end else if (r_col != 2'd3) begin
              r_col    <= r_col + 2'd1;
              r_rot_en <= 1'b1;
            end else if ((r_row_bot - 2'd1) != r_j) begin
              // Same column j, move the Givens pair one row up
              r_state   <= S_VEC;
              r_row_bot <= r_row_bot - 2'd1;
              r_row_top <= r_row_top - 2'd1;
              r_col     <= r_j;
              r_vec_en  <= 1'b1;
            end else if (r_j != 2'd2) begin
              // Column j fully zeroed below the diagonal, restart at the bottom row
              r_state   <= S_VEC;
              r_j       <= r_j + 2'd1;
              r_row_bot <= 2'd3;
              r_row_top <= 2'd2;
              r_col     <= r_j + 2'd1;
              r_vec_en  <= 1'b1;
            end else begin
              // Last Givens step done: R is in the buffer
              r_state     <= S_OUT;
              r_j         <= '0;
              r_row_bot   <= '0;
              r_row_top   <= '0;
              r_col       <= '0;
              r_out_valid <= 1'b1;
              r_rd_addr   <= '0;
            end
          end else if (r_iter == ITER_LAST) begin
            // Micro-rotations finished: PE result written back to the lower row
            r_vec_en  <= 1'b0;
            r_rot_en  <= 1'b0;
            r_wb      <= 1'b1;
            r_wr_en   <= 1'b1;
            r_wr_addr <= ADDR_W'({r_row_bot, r_col});
            r_iter    <= ITER_WB;
          end else begin
            r_iter <= r_iter + 4'd1;
          end
        end

        S_OUT: begin
          if (r_out_valid && io_sched.out_ready) begin
            if (r_rd_addr == ADDR_LAST) begin
              r_out_valid <= 1'b0;
              r_done      <= 1'b1;
              r_busy      <= 1'b0;
              r_rd_addr   <= '0;
              r_load_cnt  <= '0;
              r_state     <= S_IDLE;
            end else begin
              r_rd_addr <= r_rd_addr + ADDR_ONE;
            end
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_qrd_givens_sched.sv
// Scoreboard bench for qrd_givens_sched. The driver pushes expected load
// addresses, the Givens op list and the R read order into queues; a monitor
// on the falling edge pops and compares whenever the DUT shows a write, an op,
// an accepted R beat or done.
module tb_qrd_givens_sched;

  localparam int RN = 14;

  typedef struct {
    bit is_vec;
    int top;
    int bot;
    int col;
  } op_t;

  logic clk = 1'b0;
  logic rst_n;

  qrd_givens_sched_if #(.ADDR_W(4)) sched_if ();

  qrd_givens_sched #(
    .ROTATION_NUM (RN),
    .ADDR_W       (4)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .io_sched (sched_if)
  );

  always #5 clk = ~clk;

  int  n_vec  = 0;
  int  n_fail = 0;
  bit  mon_en = 1'b0;

  int  exp_wr_q[$];
  int  exp_rd_q[$];
  op_t op_q[$];
  int  exp_ops   = 0;
  int  exp_sched = 0;
  int  done_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: Givens schedule written as plain nested loops
  task automatic push_schedule();
    int n = 0;
    for (int j = 0; j < 3; j++) begin
      for (int i = 3; i > j; i--) begin
        op_q.push_back('{1'b1, i - 1, i, j});
        n++;
        for (int k = j + 1; k < 4; k++) begin
          op_q.push_back('{1'b0, i - 1, i, k});
          n++;
        end
      end
    end
    exp_ops   = n;
    exp_sched = n * (RN + 1);
    for (int a = 0; a < 16; a++) exp_rd_q.push_back(a);
  endtask

  // Monitor / scoreboard
  op_t cur;
  bit  op_active = 1'b0;
  int  op_cyc = 0;
  int  sched_cyc = 0;
  int  wb_cnt = 0;
  int  beats = 0;
  bit  prev_done = 1'b0;

  always @(negedge clk) begin
    if (!mon_en) begin
      op_active = 1'b0;
      op_cyc    = 0;
      sched_cyc = 0;
      wb_cnt    = 0;
      beats     = 0;
      prev_done = 1'b0;
    end else begin
      if (sched_if.busy && !sched_if.in_ready && !sched_if.out_valid && !sched_if.done)
        sched_cyc++;

      if (sched_if.vec_en || sched_if.rot_en) begin
        chk("vec_rot_exclusive", 32'(sched_if.vec_en & sched_if.rot_en), 0);
        chk("wb_during_op", 32'(sched_if.wb), 0);
        if (!op_active) begin
          if (op_q.size() == 0) begin
            chk("op_expected", op_q.size(), 1);
          end else begin
            cur = op_q.pop_front();
            op_active = 1'b1;
            op_cyc = 0;
            chk("op_row_top", 32'(sched_if.row_top), cur.top);
            chk("op_row_bot", 32'(sched_if.row_bot), cur.bot);
            chk("op_col", 32'(sched_if.col), cur.col);
          end
        end
        chk("op_kind", 32'(sched_if.vec_en), 32'(cur.is_vec));
        chk("iter", 32'(sched_if.iter), op_cyc);
        chk("in_ready_sched", 32'(sched_if.in_ready), 0);
        op_cyc++;
      end else if (sched_if.wb) begin
        chk("wb_slot", op_active ? op_cyc : -1, RN);
        chk("wb_iter", 32'(sched_if.iter), RN);
        chk("wb_wr_en", 32'(sched_if.wr_en), 1);
        chk("wb_wr_addr", 32'(sched_if.wr_addr), 4 * cur.bot + cur.col);
        op_active = 1'b0;
        wb_cnt++;
      end

      if (sched_if.wr_en && !sched_if.wb) begin
        if (exp_wr_q.size() == 0) chk("load_write_expected", exp_wr_q.size(), 1);
        else chk("load_addr", 32'(sched_if.wr_addr), exp_wr_q.pop_front());
      end

      if (sched_if.out_valid && sched_if.out_ready) begin
        if (exp_rd_q.size() == 0) chk("rd_beat_expected", exp_rd_q.size(), 1);
        else chk("rd_addr", 32'(sched_if.rd_addr), exp_rd_q.pop_front());
        beats++;
      end

      if (sched_if.done) begin
        chk("done_single_cycle", 32'(prev_done), 0);
        chk("done_beats", beats, 16);
        chk("sched_cycles", sched_cyc, exp_sched);
        chk("wb_count", wb_cnt, exp_ops);
        chk("ops_left", op_q.size(), 0);
        chk("done_busy", 32'(sched_if.busy), 0);
        chk("done_out_valid", 32'(sched_if.out_valid), 0);
`ifdef QRD_CYCLE_CNT_EN
        chk("cycle_cnt", 32'(sched_if.cycle_cnt), exp_sched);
`endif
        done_total++;
        sched_cyc = 0;
        wb_cnt    = 0;
        beats     = 0;
      end
      prev_done = sched_if.done;
    end
  end

  // Drive 16 samples; stall_before inserts a gap before that sample index
  task automatic load_matrix(input int stall_before, input int stall_len, input bit rand_gap);
    int k = 0;
    int gap = stall_len;
    while (k < 16) begin
      if (k == stall_before && gap > 0) begin
        sched_if.valid_i = 1'b0;
        repeat (gap) begin @(posedge clk); #1; end
        gap = 0;
      end else if (rand_gap && $urandom_range(0, 3) == 0) begin
        sched_if.valid_i = 1'b0;
        @(posedge clk); #1;
      end else begin
        sched_if.valid_i = 1'b1;
        chk("in_ready_load", 32'(sched_if.in_ready), 1);
        exp_wr_q.push_back(k);
        if (k == 15) push_schedule();
        k++;
        @(posedge clk); #1;
      end
    end
  endtask

  // Run one matrix end to end; rmode 0: ready=1, 1: toggling, 2: random
  task automatic run_matrix(input int stall_before, input int stall_len, input bit rand_gap,
                            input bit hold_valid, input int rmode);
    int guard = 0;
    int done_before = done_total;
    bit phase = 1'b1;
    sched_if.out_ready = 1'b0;
    load_matrix(stall_before, stall_len, rand_gap);
    sched_if.valid_i = hold_valid;
    while (!sched_if.done && guard < 3000) begin
      case (rmode)
        0:       sched_if.out_ready = 1'b1;
        1:       begin sched_if.out_ready = phase; phase = ~phase; end
        default: sched_if.out_ready = 1'($urandom_range(0, 1));
      endcase
      @(posedge clk); #1;
      guard++;
    end
    chk("done_seen", 32'(sched_if.done), 1);
    sched_if.valid_i   = 1'b0;
    sched_if.out_ready = 1'b0;
    @(posedge clk); #1;
    chk("done_pulses", done_total - done_before, 1);
    chk("idle_busy", 32'(sched_if.busy), 0);
    chk("idle_in_ready", 32'(sched_if.in_ready), 1);
    chk("idle_done_low", 32'(sched_if.done), 0);
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_busy"}, 32'(sched_if.busy), 0);
    chk({tag, "_in_ready"}, 32'(sched_if.in_ready), 1);
    chk({tag, "_vec_en"}, 32'(sched_if.vec_en), 0);
    chk({tag, "_rot_en"}, 32'(sched_if.rot_en), 0);
    chk({tag, "_wr_en"}, 32'(sched_if.wr_en), 0);
    chk({tag, "_wb"}, 32'(sched_if.wb), 0);
    chk({tag, "_iter"}, 32'(sched_if.iter), 0);
    chk({tag, "_out_valid"}, 32'(sched_if.out_valid), 0);
    chk({tag, "_done"}, 32'(sched_if.done), 0);
    chk({tag, "_rd_addr"}, 32'(sched_if.rd_addr), 0);
    chk({tag, "_row_bot"}, 32'(sched_if.row_bot), 0);
    chk({tag, "_col"}, 32'(sched_if.col), 0);
`ifdef QRD_CYCLE_CNT_EN
    chk({tag, "_cycle_cnt"}, 32'(sched_if.cycle_cnt), 0);
`endif
  endtask

  // Watchdog so the run always ends
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int guard;
    rst_n = 1'b0;
    sched_if.valid_i   = 1'b0;
    sched_if.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_state("reset");
    rst_n  = 1'b1;
    mon_en = 1'b1;
    @(posedge clk); #1;

    // Back-to-back load, valid_i held high afterwards, ready always high
    run_matrix(-1, 0, 1'b0, 1'b1, 0);
    // Stall of 5 cycles after sample 7, out_ready toggling
    run_matrix(8, 5, 1'b0, 1'b0, 1);
    // Random load gaps, random backpressure, valid_i held high
    run_matrix(-1, 0, 1'b1, 1'b1, 2);

    // Asynchronous reset in the middle of a rotation op
    load_matrix(-1, 0, 1'b0);
    sched_if.valid_i = 1'b0;
    guard = 0;
    while (!sched_if.rot_en && guard < 1000) begin
      @(posedge clk); #1;
      guard++;
    end
    repeat (3) begin @(posedge clk); #1; end
    chk("rot_reached", 32'(sched_if.rot_en), 1);
    #3;
    mon_en = 1'b0;
    rst_n  = 1'b0;
    #1;
    check_reset_state("abort");
    exp_wr_q.delete();
    exp_rd_q.delete();
    op_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n  = 1'b1;
    mon_en = 1'b1;
    @(posedge clk); #1;

    // Recovery after abort
    run_matrix(-1, 0, 1'b1, 1'b0, 2);

    chk("done_total", done_total, 4);
    chk("load_q_empty", exp_wr_q.size(), 0);
    chk("rd_q_empty", exp_rd_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
